receive_pcs: RTL

- PCS receive stage of the 1000BASE-X datapath; sits directly downstream of the code-group synchronizer.
- Consumes SUDI (code group plus rx_even) and code_sync_status, decodes 10b code groups to octets, and runs the clause-36-style receive state machine.
- Drives the GMII-side receive signals RXD, RX_DV and RX_ER.
- Works in loopback with the transmitter: transmitter, then synchronizer, then this block.

---
 rtl/receive_pcs.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/receive_pcs.sv
// 1000BASE-X PCS receive stage: decodes 10b groups from the synchronizer,
// runs the receive state machine, and drives the GMII receive signals.
module receive_pcs #(
  parameter logic [7:0] PREAMBLE_BYTE      = 8'h55,
  parameter logic [7:0] FALSE_CARRIER_BYTE = 8'h0E
) (
  input  logic        Clk,
  input  logic        mr_main_reset,
  input  logic        code_sync_status,
  input  logic [10:0] SUDI,
  output logic [7:0]  RXD,
  output logic        RX_DV,
  output logic        RX_ER,
  output logic        receiving
);

  localparam logic [2:0] LINK_FAILED     = 3'd0;
  localparam logic [2:0] WAIT_FOR_K      = 3'd1;
  localparam logic [2:0] RX_K            = 3'd2;
  localparam logic [2:0] IDLE_D          = 3'd3;
  localparam logic [2:0] START_OF_PACKET = 3'd4;
  localparam logic [2:0] RECEIVE         = 3'd5;
  localparam logic [2:0] TRI_RRI         = 3'd6;

  // Special code groups, both running-disparity columns (abcdei_fghj)
  localparam logic [9:0] K28_5_N = 10'b001111_1010;
  localparam logic [9:0] K28_5_P = 10'b110000_0101;
  localparam logic [9:0] K27_7_N = 10'b110110_1000;
  localparam logic [9:0] K27_7_P = 10'b001001_0111;
  localparam logic [9:0] K29_7_N = 10'b101110_1000;
  localparam logic [9:0] K29_7_P = 10'b010001_0111;
  localparam logic [9:0] K23_7_N = 10'b111010_1000;
  localparam logic [9:0] K23_7_P = 10'b000101_0111;

  logic [10:0] g1_q;
  logic [2:0]  state_q, state_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rx_dv_q, rx_dv_d, rx_er_q, rx_er_d, receiving_q, receiving_d;

  logic [4:0] dec5;
  logic [2:0] dec3;
  logic       v6, v4, alt7, a7_x, d_valid;
  logic       is_k28_5, is_s, is_t, is_r, la_r;
  logic [7:0] err_octet;

  // 5b/6b decode of abcdei, either disparity column
  always_comb begin
    v6   = 1'b1;
    dec5 = 5'd0;
    case (g1_q[9:4])
      6'b100111, 6'b011000: dec5 = 5'd0;
      6'b011101, 6'b100010: dec5 = 5'd1;
      6'b101101, 6'b010010: dec5 = 5'd2;
      6'b110001:            dec5 = 5'd3;
      6'b110101, 6'b001010: dec5 = 5'd4;
      6'b101001:            dec5 = 5'd5;
      6'b011001:            dec5 = 5'd6;
      6'b111000, 6'b000111: dec5 = 5'd7;
      6'b111001, 6'b000110: dec5 = 5'd8;
      6'b100101:            dec5 = 5'd9;
      6'b010101:            dec5 = 5'd10;
      6'b110100:            dec5 = 5'd11;
      6'b001101:            dec5 = 5'd12;
      6'b101100:            dec5 = 5'd13;
      6'b011100:            dec5 = 5'd14;
      6'b010111, 6'b101000: dec5 = 5'd15;
      6'b011011, 6'b100100: dec5 = 5'd16;
      6'b100011:            dec5 = 5'd17;
      6'b010011:            dec5 = 5'd18;
      6'b110010:            dec5 = 5'd19;
      6'b001011:            dec5 = 5'd20;
      6'b101010:            dec5 = 5'd21;
      6'b011010:            dec5 = 5'd22;
      6'b111010, 6'b000101: dec5 = 5'd23;
      6'b110011, 6'b001100: dec5 = 5'd24;
      6'b100110:            dec5 = 5'd25;
      6'b010110:            dec5 = 5'd26;
      6'b110110, 6'b001001: dec5 = 5'd27;
      6'b001110:            dec5 = 5'd28;
      6'b101110, 6'b010001: dec5 = 5'd29;
      6'b011110, 6'b100001: dec5 = 5'd30;
      6'b101011, 6'b010100: dec5 = 5'd31;
      default:              v6   = 1'b0;
    endcase
  end

  // 3b/4b decode of fghj; alt7 flags the D.x.A7 form
  always_comb begin
    v4   = 1'b1;
    alt7 = 1'b0;
    dec3 = 3'd0;
    case (g1_q[3:0])
      4'b1011, 4'b0100: dec3 = 3'd0;
      4'b1001:          dec3 = 3'd1;
      4'b0101:          dec3 = 3'd2;
      4'b1100, 4'b0011: dec3 = 3'd3;
      4'b1101, 4'b0010: dec3 = 3'd4;
      4'b1010:          dec3 = 3'd5;
      4'b0110:          dec3 = 3'd6;
      4'b1110, 4'b0001: dec3 = 3'd7;
      4'b0111, 4'b1000: begin
        dec3 = 3'd7;
        alt7 = 1'b1;
      end
      default:          v4   = 1'b0;
    endcase
  end

  // A7 only legal for these x; elsewhere 0111/1000 marks a K.x.7 group
  assign a7_x    = dec5 inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20};
  assign d_valid = v6 && v4 && (!alt7 || a7_x);

  assign is_k28_5 = (g1_q[9:0] == K28_5_N) || (g1_q[9:0] == K28_5_P);
  assign is_s     = (g1_q[9:0] == K27_7_N) || (g1_q[9:0] == K27_7_P);
  assign is_t     = (g1_q[9:0] == K29_7_N) || (g1_q[9:0] == K29_7_P);
  assign is_r     = (g1_q[9:0] == K23_7_N) || (g1_q[9:0] == K23_7_P);
  assign la_r     = (SUDI[9:0] == K23_7_N) || (SUDI[9:0] == K23_7_P);

  // Octet reported during error propagation: special's octet, else 0
  always_comb begin
    if (is_k28_5)   err_octet = 8'hBC;
    else if (is_s)  err_octet = 8'hFB;
    else if (is_t)  err_octet = 8'hFD;
    else if (is_r)  err_octet = 8'hF7;
    else            err_octet = 8'h00;
  end

  // Next state and next registered outputs from g1 plus live lookahead
  always_comb begin
    state_d     = state_q;
    rxd_d       = 8'h00;
    rx_dv_d     = 1'b0;
    rx_er_d     = 1'b0;
    receiving_d = 1'b0;
    if (!code_sync_status) begin
      state_d = LINK_FAILED;
      rx_er_d = receiving_q;
    end else begin
      unique case (state_q)
        LINK_FAILED: state_d = WAIT_FOR_K;
        WAIT_FOR_K: if (is_k28_5 && g1_q[10]) state_d = RX_K;
        RX_K:       state_d = d_valid ? IDLE_D : WAIT_FOR_K;
        IDLE_D: begin
          if (is_k28_5) begin
            state_d = RX_K;
          end else if (is_s) begin
            state_d     = START_OF_PACKET;
            rxd_d       = PREAMBLE_BYTE;
            rx_dv_d     = 1'b1;
            receiving_d = 1'b1;
          end else begin
            state_d = WAIT_FOR_K;
            rxd_d   = FALSE_CARRIER_BYTE;
            rx_er_d = 1'b1;
          end
        end
        // Preamble already emitted on entry, so SOP handles its group like RECEIVE
        START_OF_PACKET, RECEIVE: begin
          state_d = RECEIVE;
          if (d_valid) begin
            rxd_d       = {dec3, dec5};
            rx_dv_d     = 1'b1;
            receiving_d = 1'b1;
          end else if (is_t && la_r) begin
            state_d = TRI_RRI;
          end else if (is_k28_5 && g1_q[10]) begin
            state_d = RX_K;
            rx_dv_d = 1'b1;
            rx_er_d = 1'b1;
          end else begin
            rxd_d       = err_octet;
            rx_dv_d     = 1'b1;
            rx_er_d     = 1'b1;
            receiving_d = 1'b1;
          end
        end
        TRI_RRI: begin
          if (is_r)          state_d = TRI_RRI;
          else if (is_k28_5) state_d = RX_K;
          else               state_d = WAIT_FOR_K;
        end
        default: state_d = LINK_FAILED;
      endcase
    end
  end

  // Lookahead capture, state and output registers
  always_ff @(posedge Clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      g1_q        <= 11'd0;
      state_q     <= LINK_FAILED;
      rxd_q       <= 8'h00;
      rx_dv_q     <= 1'b0;
      rx_er_q     <= 1'b0;
      receiving_q <= 1'b0;
    end else begin
      g1_q        <= SUDI;
      state_q     <= state_d;
      rxd_q       <= rxd_d;
      rx_dv_q     <= rx_dv_d;
      rx_er_q     <= rx_er_d;
      receiving_q <= receiving_d;
    end
  end

  assign RXD       = rxd_q;
  assign RX_DV     = rx_dv_q;
  assign RX_ER     = rx_er_q;
  assign receiving = receiving_q;

endmodule
